// File: rtl/controlador_soma_serial.sv
// Bit-serial 4-bit adder with carry-in, followed by a binary-to-BCD conversion
// of the 5-bit sum by repeated subtraction of ten.
module controlador_soma_serial (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic       busy,
    output logic       done,
    output logic [4:0] soma,
    output logic [3:0] bcd_dez,
    output logic [3:0] bcd_un
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SOMA = 2'd1,
        BCD  = 2'd2,
        FIM  = 2'd3
    } state_t;

    state_t     state, next_state;
    logic [3:0] a_sh, b_sh, sum_sh;
    logic       carry;
    logic [1:0] cnt;
    logic [4:0] sum_w;
    logic [4:0] units;
    logic [1:0] tens;
    logic       fa_s, fa_c;

    // The single shared full adder always works on the current LSBs.
    assign fa_s = a_sh[0] ^ b_sh[0] ^ carry;
    assign fa_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: default first, so no path through the case leaves next_state
        // unassigned and no latch is inferred.
        next_state = state;
        case (state)
            IDLE: if (start) next_state = SOMA;
            SOMA: if (cnt == 2'd3) next_state = BCD;
            BCD:  if (units < 5'd10) next_state = FIM;
            FIM:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            sum_w   <= '0;
            units   <= '0;
            tens    <= '0;
            done    <= 1'b0;
            soma    <= '0;
            bcd_dez <= '0;
            bcd_un  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                SOMA: begin
                    a_sh   <= {1'b0, a_sh[3:1]};
                    b_sh   <= {1'b0, b_sh[3:1]};
                    carry  <= fa_c;
                    sum_sh <= {fa_s, sum_sh[3:1]};
                    if (cnt != 2'd3) begin
                        cnt <= cnt + 2'd1;
                    end else begin
                        sum_w <= {fa_c, fa_s, sum_sh[3:1]};
                        units <= {fa_c, fa_s, sum_sh[3:1]};
                        tens  <= '0;
                    end
                end
                BCD: begin
                    if (units >= 5'd10) begin
                        units <= units - 5'd10;
                        tens  <= tens + 2'd1;
                    end else begin
                        // Results load on the edge entering FIM so they are
                        // already valid while done is high.
                        soma    <= sum_w;
                        bcd_dez <= {2'b00, tens};
                        bcd_un  <= units[3:0];
                        done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_soma_serial.sv
// Directed bench for controlador_soma_serial: scoreboarded results, latency,
// busy/done timing, ignored start, reset abort and back-to-back operation.
module tb_controlador_soma_serial;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       cin = 1'b0;
    logic       busy, done;
    logic [4:0] soma;
    logic [3:0] bcd_dez, bcd_un;

    controlador_soma_serial dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .soma    (soma),
        .bcd_dez (bcd_dez),
        .bcd_un  (bcd_un)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] s;
        logic [3:0] d;
        logic [3:0] u;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [4:0] prev_s = '0;
    logic [3:0] prev_d = '0;
    logic [3:0] prev_u = '0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives a one-cycle start in an IDLE cycle; acceptance edge is "edge 0".
    task automatic issue(input logic [3:0] a_v, input logic [3:0] b_v, input logic cin_v);
        exp_t e;
        int   sum;
        @(negedge clk);
        check("idle_busy", {7'd0, busy}, 8'd0);
        check("idle_done", {7'd0, done}, 8'd0);
        a     = a_v;
        b     = b_v;
        cin   = cin_v;
        start = 1'b1;
        sum   = int'(a_v) + int'(b_v) + int'(cin_v);
        e.s   = 5'(sum);
        e.d   = 4'(sum / 10);
        e.u   = 4'(sum % 10);
        e.lat = 6 + sum / 10;
        sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Samples each cycle on the falling edge; optionally disturbs inputs and
    // pulses start mid-operation to show they are ignored.
    task automatic wait_done(input string tag, input bit disturb);
        exp_t e;
        int   lat;
        bit   got;
        got = 1'b0;
        lat = (sb.size() > 0) ? sb[0].lat : 6;
        for (int n = 1; n <= 12 && !got; n++) begin
            @(negedge clk);
            if (disturb && n == 2) begin
                a = 4'd15; b = 4'd0; cin = 1'b1; start = 1'b1;
            end
            if (disturb && n == 3) start = 1'b0;
            if (done) begin
                got = 1'b1;
                e = sb.pop_front();
                check({tag, "_latency"}, 8'(n), 8'(e.lat));
                check({tag, "_busy_at_done"}, {7'd0, busy}, 8'd1);
                check({tag, "_soma"}, {3'd0, soma}, {3'd0, e.s});
                check({tag, "_dez"}, {4'd0, bcd_dez}, {4'd0, e.d});
                check({tag, "_un"}, {4'd0, bcd_un}, {4'd0, e.u});
                prev_s = e.s; prev_d = e.d; prev_u = e.u;
            end else begin
                check({tag, "_busy"}, {7'd0, busy}, {7'd0, (n <= lat)});
                check({tag, "_hold_soma"}, {3'd0, soma}, {3'd0, prev_s});
                check({tag, "_hold_dez"}, {4'd0, bcd_dez}, {4'd0, prev_d});
                check({tag, "_hold_un"}, {4'd0, bcd_un}, {4'd0, prev_u});
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout observed=no_done expected=done_in_cycle_%0d", tag, lat);
            if (sb.size() > 0) void'(sb.pop_front());
        end
    endtask

    initial begin
        #12;
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_done", {7'd0, done}, 8'd0);
        check("rst_soma", {3'd0, soma}, 8'd0);
        check("rst_dez", {4'd0, bcd_dez}, 8'd0);
        check("rst_un", {4'd0, bcd_un}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(4'd9, 4'd5, 1'b0);    wait_done("op_9_5", 1'b0);
        issue(4'd15, 4'd15, 1'b1);  wait_done("op_max", 1'b0);
        issue(4'd0, 4'd0, 1'b0);    wait_done("op_zero", 1'b0);
        issue(4'd7, 4'd8, 1'b1);    wait_done("op_7_8_1", 1'b0);
        issue(4'd3, 4'd4, 1'b0);    wait_done("op_ignore", 1'b1);

        // Abort an operation with reset in cycle 3.
        issue(4'd8, 4'd8, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {7'd0, busy}, 8'd0);
        check("abort_done", {7'd0, done}, 8'd0);
        check("abort_soma", {3'd0, soma}, 8'd0);
        check("abort_dez", {4'd0, bcd_dez}, 8'd0);
        check("abort_un", {4'd0, bcd_un}, 8'd0);
        void'(sb.pop_front());
        prev_s = '0; prev_d = '0; prev_u = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", {7'd0, done}, 8'd0);
        end
        rst_n = 1'b1;
        issue(4'd1, 4'd1, 1'b1);    wait_done("post_rst", 1'b0);

        // Back-to-back: second start in the first IDLE cycle after FIM.
        issue(4'd5, 4'd5, 1'b0);    wait_done("b2b_first", 1'b0);
        issue(4'd2, 4'd0, 1'b0);    wait_done("b2b_second", 1'b0);

        check("sb_empty", 8'(sb.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/controlador_soma_serial.md
CONTROLADOR_SOMA_SERIAL -- requirements
Module: controlador_soma_serial

Interface
REQ-001 Parameters: none; operand width SHALL be fixed at 4 bits, result width at 5 bits.
REQ-002 clk  input  1  single system clock; all state SHALL change on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request pulse; SHALL be accepted only in state IDLE.
REQ-005 a  input  4  operand A, unsigned; sampled only on start acceptance.
REQ-006 b  input  4  operand B, unsigned; sampled only on start acceptance.
REQ-007 cin  input  1  carry-in; sampled only on start acceptance.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  one-cycle pulse marking new results valid.
REQ-010 soma  output  5  registered binary result a+b+cin, range 0..31.
REQ-011 bcd_dez  output  4  registered tens digit of soma, range 0..3.
REQ-012 bcd_un  output  4  registered units digit of soma, range 0..9.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, SOMA, BCD and FIM.
REQ-014 IDLE with start=1: latch a, b and cin into working shift registers, clear bit counter to 0, go to SOMA.
REQ-015 IDLE with start=0: remain in IDLE; working and result registers hold.
REQ-016 Addition SHALL use one shared 1-bit full adder, bit-serial, LSB first, one bit per SOMA cycle.
REQ-017 Carry register: loaded with cin at acceptance, then updated with the adder carry-out each SOMA cycle.
REQ-018 SOMA SHALL last exactly 4 cycles (counter 0..3), then go to BCD.
REQ-019 On SOMA exit, the working units register SHALL take the full 5-bit sum (final carry in bit 4), and the working tens register SHALL be cleared to 0.
REQ-020 BCD: if units >= 10, subtract 10 from units, increment tens, stay in BCD; else go to FIM.
REQ-021 FIM: load soma, bcd_dez and bcd_un from the working registers, assert done for that one cycle, return to IDLE.
REQ-022 soma, bcd_dez and bcd_un SHALL change only on the FIM load and SHALL otherwise hold their last values.
REQ-023 Latency, with start accepted at edge 0: SOMA covers cycles 1-4; BCD covers cycles 5..5+k, where k = sum/10 (integer); done is high in cycle 6+k.
REQ-024 Result bounds: minimum latency is 6 cycles (sum 0..9); maximum is 9 cycles (sum 30..31).
REQ-025 start while busy=1 SHALL be ignored, with no queuing and no effect on the operation in progress.
REQ-026 Changes on a, b or cin after acceptance SHALL NOT affect the operation in progress.
REQ-027 start in the first IDLE cycle after FIM SHALL be accepted (back-to-back operation).
REQ-028 Counters SHALL NOT wrap: the bit counter is used only for 0..3, and tens never exceeds 3.

Reset
REQ-029 rst_n=0 SHALL immediately, independent of clk, force state IDLE and clear busy, done, soma, bcd_dez, bcd_un, the working registers, the carry and the counter to 0.
REQ-030 Reset asserted mid-operation SHALL abort it: no done pulse, and results read 0.
REQ-031 After rst_n deasserts, the first start SHALL be accepted on the next rising clk edge.

Verification
REQ-032 a=9, b=5, cin=0, start at edge 0 -> done high in cycle 7 only; soma=14, bcd_dez=1, bcd_un=4; busy high in cycles 1-7.
REQ-033 a=15, b=15, cin=1 -> done in cycle 9; soma=31, bcd_dez=3, bcd_un=1.
REQ-034 a=0, b=0, cin=0 -> done in cycle 6; soma=0, bcd_dez=0, bcd_un=0.
REQ-035 Start with a=3, b=4, then change a to 15 and pulse start in cycle 2 -> single done in cycle 6; soma=7, dez=0, un=7.
REQ-036 Start with a=8, b=8, then pull rst_n low in cycle 3 -> outputs 0 immediately, no done; a new start with a=1, b=1, cin=1 after release -> soma=3.
REQ-037 Back-to-back: a=5, b=5 (soma=10, done in cycle 7), then start again in the next IDLE cycle with a=2, b=0 -> second done 6 cycles after that acceptance; result registers hold 10 until then.
